alu_exec: RTL
=============

Name: alu_exec

Overview:
- Execution stage directly downstream of the ALU control decoder; consumes its 4-bit operation code plus two operands and produces the registered result.
- Single-cycle ops (add/sub/move/swap/and/or/compare) complete in 1 cycle.
- Mult and div run as iterative multi-cycle units under a start/busy/done handshake, so the main control stalls on busy.

Parameters:
- DATA_W, 16, operand/result width in bits (>= 4).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request: launch operation; sampled only in IDLE
- operation  input  4  op code from ALU control (encoding below)
- a  input  DATA_W  operand A (rs)
- b  input  DATA_W  operand B (rt/immediate)
- busy  output  1  high while a mult/div iteration is in progress
- done  output  1  one-cycle pulse: result/flags valid
- result  output  DATA_W  primary result (product low / quotient)
- result_hi  output  DATA_W  product high / remainder / swap second word
- zero  output  1  compare: a==b; other ops: result==0
- lt  output  1  compare only: signed a<b; 0 for other ops
- div_err  output  1  set with done when div by b==0

Behaviour:
- Op encoding:
  - 0000 nop/jump/halt
  - 0001 add
  - 0010 sub
  - 0011 mult
  - 0100 div
  - 0101 move
  - 0110 swap
  - 0111 and
  - 1000 or
  - 1001 compare
  - 1010-1111 illegal, treated as nop
- Reset (async, any time incl. mid-mult/div): state=IDLE, busy=0, done=0, result=0, result_hi=0, zero=0, lt=0, div_err=0, counter=0. The in-flight operation is discarded, not resumed.
- States:
  - IDLE: start=1 with single-cycle op, nop, or div with b==0 -> DONE.
  - IDLE: start=1 with mult -> MUL. With div, b!=0 -> DIV.
  - IDLE: start=0 -> stay.
  - MUL/DIV: counter counts DATA_W iterations -> DONE after last.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Latency (start high in cycle k):
  - done high in cycle k+1 for single-cycle ops, nop, and div-by-zero.
  - done high in cycle k+DATA_W+1 for mult and div.
- busy=1 in every MUL/DIV cycle, 0 in IDLE and DONE.
- start while busy or in DONE is ignored; no queuing. Operands and operation are captured at the start edge; later input changes have no effect.
- Results:
  - add/sub: modulo 2^DATA_W, result_hi=0.
  - move: result=b, result_hi=0.
  - swap: result=b, result_hi=a.
  - and/or: bitwise, result_hi=0.
  - compare: result=0, result_hi=0, zero=(a==b), lt=signed(a)<signed(b).
  - nop/illegal: result=0, result_hi=0, zero=1.
- mult: unsigned shift-add, one bit per cycle, LSB first. Full 2*DATA_W product; {result_hi,result}=a*b.
- div: unsigned restoring, one quotient bit per cycle, MSB first. result=a/b, result_hi=a%b.
- div b==0: result=all ones, result_hi=a, div_err=1, zero=0.
- div_err=0 for every other completion.
- Outputs hold their values from one done until the next done (or reset); only done pulses.
- Back-to-back: start may be high in the DONE cycle+1 (IDLE), giving a minimum issue interval of 2 cycles.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: extra output port ovf (1 bit), updated with done.
  - add: signed overflow (operands same sign, result differs).
  - sub: signed overflow (operands differ in sign, result sign differs from a).
  - mult: ovf=1 if result_hi != 0.
  - all other ops: ovf=0.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. DATA_W=16: reset asserted mid-operation while busy=1 -> all outputs 0 at once, busy=0. After release, IDLE accepts start next cycle.
2. add a=0x7FFF, b=0x0001 -> done at k+1, result=0x8000, zero=0 (ALU_OVF_EN: ovf=1). sub a=5, b=5 -> result=0, zero=1.
3. mult a=0xFFFF, b=0xFFFF -> busy for 16 cycles, done at k+17, result=0x0001, result_hi=0xFFFE. start pulses during busy are ignored.
4. div a=100, b=7 -> done at k+17, result=14, result_hi=2, div_err=0. div a=0x1234, b=0 -> done at k+1, result=0xFFFF, result_hi=0x1234, div_err=1.
5. compare a=0xFFFE(-2), b=0x0003 -> lt=1, zero=0. swap a=0xAAAA, b=0x5555 -> result=0x5555, result_hi=0xAAAA.
6. operation=1100 (illegal) -> done at k+1, result=0, zero=1. Then and a=0xF0F0, b=0xFF00 at the next start -> result=0xF000.

Source files
------------

// File: rtl/alu_exec.sv
// Execution stage: single-cycle ALU ops plus iterative shift-add multiply and restoring divide.
// Optional signed/unsigned overflow flag output enabled by defining ALU_OVF_EN.
module alu_exec #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        operation,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] result_hi,
   output logic              zero,
   output logic              lt,
   output logic              div_err
`ifdef ALU_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_DIV  = 4'b0100;
   localparam logic [3:0] OP_MOVE = 4'b0101;
   localparam logic [3:0] OP_SWAP = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_OR   = 4'b1000;
   localparam logic [3:0] OP_CMP  = 4'b1001;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
   logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
   logic [DATA_W-1:0]   opnd_q, opnd_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [DATA_W-1:0]   result_hi_q, result_hi_d;
   logic                zero_q, zero_d;
   logic                lt_q, lt_d;
   logic                div_err_q, div_err_d;

   logic [DATA_W:0]     mul_sum_s;
   logic [DATA_W-1:0]   mul_hi_s, mul_lo_s;
   logic [DATA_W:0]     div_trial_s, div_diff_s;
   logic [DATA_W-1:0]   div_rem_s, div_quo_s;
   logic [DATA_W-1:0]   sc_res_s, sc_hi_s;
   logic                sc_zero_s, sc_lt_s;

   // One iteration step of each multi-cycle unit; acc_hi/acc_lo hold product or remainder/quotient.
   always_comb begin
      mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
      mul_hi_s  = mul_sum_s[DATA_W:1];
      mul_lo_s  = {mul_sum_s[0], acc_lo_q[DATA_W-1:1]};
      div_trial_s = {acc_hi_q, acc_lo_q[DATA_W-1]};
      div_diff_s  = div_trial_s - {1'b0, opnd_q};
      if (!div_diff_s[DATA_W]) begin
         div_rem_s = div_diff_s[DATA_W-1:0];
         div_quo_s = {acc_lo_q[DATA_W-2:0], 1'b1};
      end else begin
         div_rem_s = div_trial_s[DATA_W-1:0];
         div_quo_s = {acc_lo_q[DATA_W-2:0], 1'b0};
      end
   end

   // Single-cycle result computation from the live operands at the start edge.
   always_comb begin
      sc_res_s = {DATA_W{1'b0}};
      sc_hi_s  = {DATA_W{1'b0}};
      sc_lt_s  = 1'b0;
      case (operation)
         OP_ADD:  sc_res_s = a + b;
         OP_SUB:  sc_res_s = a - b;
         OP_MOVE: sc_res_s = b;
         OP_SWAP: begin
            sc_res_s = b;
            sc_hi_s  = a;
         end
         OP_AND:  sc_res_s = a & b;
         OP_OR:   sc_res_s = a | b;
         OP_CMP:  sc_lt_s  = ($signed(a) < $signed(b));
         default: sc_res_s = {DATA_W{1'b0}};
      endcase
      if (operation == OP_CMP) begin
         sc_zero_s = (a == b);
      end else begin
         sc_zero_s = (sc_res_s == {DATA_W{1'b0}});
      end
   end

   // Next-state and output-load logic; outputs only change on the edge that raises done.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_hi_d    = acc_hi_q;
      acc_lo_d    = acc_lo_q;
      opnd_d      = opnd_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      zero_d      = zero_q;
      lt_d        = lt_q;
      div_err_d   = div_err_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (start) begin
               if (operation == OP_MUL) begin
                  state_d  = S_MUL;
                  busy_d   = 1'b1;
                  acc_hi_d = {DATA_W{1'b0}};
                  acc_lo_d = b;
                  opnd_d   = a;
               end else if ((operation == OP_DIV) && (b != {DATA_W{1'b0}})) begin
                  state_d  = S_DIV;
                  busy_d   = 1'b1;
                  acc_hi_d = {DATA_W{1'b0}};
                  acc_lo_d = a;
                  opnd_d   = b;
               end else if (operation == OP_DIV) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  result_d    = {DATA_W{1'b1}};
                  result_hi_d = a;
                  zero_d      = 1'b0;
                  lt_d        = 1'b0;
                  div_err_d   = 1'b1;
               end else begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  result_d    = sc_res_s;
                  result_hi_d = sc_hi_s;
                  zero_d      = sc_zero_s;
                  lt_d        = sc_lt_s;
                  div_err_d   = 1'b0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            acc_hi_d = mul_hi_s;
            acc_lo_d = mul_lo_s;
            cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == LAST_CNT) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               result_d    = mul_lo_s;
               result_hi_d = mul_hi_s;
               zero_d      = (mul_lo_s == {DATA_W{1'b0}});
               lt_d        = 1'b0;
               div_err_d   = 1'b0;
            end else begin
               busy_d = 1'b1;
            end
         end
         S_DIV: begin
            acc_hi_d = div_rem_s;
            acc_lo_d = div_quo_s;
            cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == LAST_CNT) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               result_d    = div_quo_s;
               result_hi_d = div_rem_s;
               zero_d      = (div_quo_s == {DATA_W{1'b0}});
               lt_d        = 1'b0;
               div_err_d   = 1'b0;
            end else begin
               busy_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         acc_hi_q    <= {DATA_W{1'b0}};
         acc_lo_q    <= {DATA_W{1'b0}};
         opnd_q      <= {DATA_W{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= {DATA_W{1'b0}};
         result_hi_q <= {DATA_W{1'b0}};
         zero_q      <= 1'b0;
         lt_q        <= 1'b0;
         div_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_hi_q    <= acc_hi_d;
         acc_lo_q    <= acc_lo_d;
         opnd_q      <= opnd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         zero_q      <= zero_d;
         lt_q        <= lt_d;
         div_err_q   <= div_err_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign zero      = zero_q;
   assign lt        = lt_q;
   assign div_err   = div_err_q;

`ifdef ALU_OVF_EN
   logic sc_ovf_s;
   logic ovf_q, ovf_d;

   // Signed overflow of add/sub; mult overflow means the high product word is non-zero.
   always_comb begin
      case (operation)
         OP_ADD:  sc_ovf_s = (a[DATA_W-1] == b[DATA_W-1]) && (sc_res_s[DATA_W-1] != a[DATA_W-1]);
         OP_SUB:  sc_ovf_s = (a[DATA_W-1] != b[DATA_W-1]) && (sc_res_s[DATA_W-1] != a[DATA_W-1]);
         default: sc_ovf_s = 1'b0;
      endcase
      if (!done_d) begin
         ovf_d = ovf_q;
      end else if (state_q == S_MUL) begin
         ovf_d = (mul_hi_s != {DATA_W{1'b0}});
      end else if (state_q == S_IDLE) begin
         ovf_d = sc_ovf_s;
      end else begin
         ovf_d = 1'b0;
      end
   end

   // Overflow flag register, loaded alongside the other results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
